// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receive-side CPU controller.
package uart_pkg;

  localparam logic [1:0] RX_DATA   = 2'd0;
  localparam logic [1:0] RX_STATUS = 2'd1;
  localparam logic [1:0] RX_BAUD   = 2'd2;
  localparam logic [1:0] RX_LEVEL  = 2'd3;

  localparam int unsigned ST_NOT_EMPTY = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_OVERRUN   = 2;
  localparam int unsigned ST_IRQ_EN    = 3;

  localparam logic [2:0] BAUD_4800    = 3'b000;
  localparam logic [2:0] BAUD_9600    = 3'b001;
  localparam logic [2:0] BAUD_19200   = 3'b010;
  localparam logic [2:0] BAUD_38400   = 3'b011;
  localparam logic [2:0] BAUD_57600   = 3'b100;
  localparam logic [2:0] BAUD_115200  = 3'b101;
  localparam logic [2:0] BAUD_DEFAULT = BAUD_115200;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_ACK  = 2'd1,
    S_HOLD = 2'd2
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO for received bytes; callers only assert push/pop when legal.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + LW'(1);
      else if (pop && !push) count <= count - LW'(1);
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == LW'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

endmodule

// File: rtl/uart_rx_ctrl.sv
// CPU-side controller for the UART receiver: byte handshake, RX FIFO and 6502 register block.
// Define UART_RX_CTRL_IRQ_EN to enable the irq_en status bit and the irq output.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FRE    = 50,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  output logic       rx_data_ready,
  output logic [2:0] baudrate,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       irq
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  rx_state_e     state, state_nxt;
  logic          ready_nxt;
  logic          rd_acc, wr_acc, push, pop;
  logic          full, empty, overrun, irq_en;
  logic [7:0]    dout, status, level_rd, rdata_nxt;
  logic [LW-1:0] level;
  logic          unused_bits;

  assign unused_bits = ^{wdata[7:3], 32'(CLK_FRE)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_WAIT;
      rx_data_ready <= 1'b0;
    end else begin
      state         <= state_nxt;
      rx_data_ready <= ready_nxt;
    end
  end

  // One ready pulse per byte; S_HOLD waits for the receiver to drop valid.
  always_comb begin
    state_nxt = state;
    ready_nxt = 1'b0;
    unique case (state)
      S_WAIT: if (rx_data_valid) begin
        state_nxt = S_ACK;
        ready_nxt = 1'b1;
      end
      S_ACK:  state_nxt = S_HOLD;
      S_HOLD: if (!rx_data_valid) state_nxt = S_WAIT;
      default: state_nxt = S_WAIT;
    endcase
  end

  assign rd_acc = cs && !we;
  assign wr_acc = cs && we;
  assign pop    = rd_acc && (addr == RX_DATA) && !empty;
  assign push   = ready_nxt && (!full || pop);

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (rx_data),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    status                = 8'h00;
    status[ST_NOT_EMPTY]  = !empty;
    status[ST_FULL]       = full;
    status[ST_OVERRUN]    = overrun;
    status[ST_IRQ_EN]     = irq_en;
  end

  // A full 256-deep FIFO saturates to 0xFF; status bit1 disambiguates.
  assign level_rd = (32'(level) > 32'd255) ? 8'hFF : 8'(level);

  always_comb begin
    rdata_nxt = 8'h00;
    case (addr)
      RX_DATA:   rdata_nxt = empty ? 8'h00 : dout;
      RX_STATUS: rdata_nxt = status;
      RX_BAUD:   rdata_nxt = {5'b00000, baudrate};
      RX_LEVEL:  rdata_nxt = level_rd;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata    <= 8'h00;
      baudrate <= BAUD_DEFAULT;
      overrun  <= 1'b0;
    end else begin
      if (rd_acc) rdata <= rdata_nxt;
      if (wr_acc && addr == RX_BAUD) baudrate <= wdata[2:0];
      // A new overrun wins over a same-cycle software clear.
      overrun <= (ready_nxt && full && !pop) ||
                 (overrun && !(wr_acc && addr == RX_STATUS && wdata[2]));
    end
  end

`ifdef UART_RX_CTRL_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_acc && addr == RX_STATUS) irq_en <= wdata[3];
      irq <= irq_en && (!empty || overrun);
    end
  end
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: register table, directed corner sequences, random traffic vs a queue model.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready;
  logic [2:0] baudrate;
  logic       cs, we;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       irq;

  uart_rx_ctrl #(.CLK_FRE(50), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_data_ready(rx_data_ready), .baudrate(baudrate), .cs(cs), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: byte queue plus software-visible flags.
  logic [7:0] q[$];
  bit         m_ovr;
  bit         m_irq_en;
  logic [2:0] m_baud;
  logic [7:0] m_rdata;

  typedef struct {
    logic       w;
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    q.delete();
    m_ovr    = 0;
    m_irq_en = 0;
    m_baud   = 3'b101;
    m_rdata  = 8'h00;
  endtask

  task automatic m_push(input logic [7:0] b);
    if (q.size() < DEPTH) q.push_back(b);
    else m_ovr = 1;
  endtask

  task automatic m_cpu(input logic w, input logic [1:0] a, input logic [7:0] d);
    if (w) begin
      if (a == 2'd1) begin
        if (d[2]) m_ovr = 0;
`ifdef UART_RX_CTRL_IRQ_EN
        m_irq_en = d[3];
`endif
      end else if (a == 2'd2) begin
        m_baud = d[2:0];
      end
    end else begin
      case (a)
        2'd0: if (q.size() > 0) m_rdata = q.pop_front(); else m_rdata = 8'h00;
        2'd1: m_rdata = {4'h0, m_irq_en, m_ovr, q.size() == DEPTH, q.size() != 0};
        2'd2: m_rdata = {5'b00000, m_baud};
        default: m_rdata = 8'(q.size());
      endcase
    end
  endtask

  function automatic bit m_irq();
    return m_irq_en && (q.size() != 0 || m_ovr);
  endfunction

  task automatic cpu(input logic w, input logic [1:0] a, input logic [7:0] d, input string nm);
    cs = 1; we = w; addr = a; wdata = d;
    tick();
    cs = 0; we = 0;
    m_cpu(w, a, d);
    check(nm, rdata, m_rdata);
  endtask

  // Present a byte, hold valid until ready (plus 'hold' extra cycles), then drop it.
  // With with_cpu set, a CPU access lands on the same edge that captures the byte.
  task automatic send(input logic [7:0] b, input int hold, input bit with_cpu,
                      input logic w, input logic [1:0] a, input logic [7:0] d, input string nm);
    int pulses;
    bit seen;
    pulses = 0;
    seen   = 0;
    rx_data = b;
    rx_data_valid = 1;
    if (with_cpu) begin cs = 1; we = w; addr = a; wdata = d; end
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      cs = 0; we = 0;
      if (rx_data_ready) begin seen = 1; pulses++; end
    end
    check($sformatf("%s ready_seen", nm), 32'(seen), 1);
    if (with_cpu) begin
      m_cpu(w, a, d);
      check($sformatf("%s rdata", nm), rdata, m_rdata);
    end
    m_push(b);
    repeat (hold) begin tick(); if (rx_data_ready) pulses++; end
    rx_data_valid = 0;
    repeat (3) begin tick(); if (rx_data_ready) pulses++; end
    check($sformatf("%s pulses", nm), 32'(pulses), 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int unsigned op;
  logic [7:0]  rb;

  initial begin
    rst_n = 0; rx_data = 0; rx_data_valid = 0; cs = 0; we = 0; addr = 0; wdata = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst ready", rx_data_ready, 0);
    check("rst rdata", rdata, 8'h00);
    check("rst irq", irq, 0);
    check("rst baud", baudrate, 3'b101);
    rst_n = 1;
    tick();

    // Register table from reset.
    tbl.push_back('{1'b0, 2'd1, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 2'd2, 8'h00, 8'h05});
    tbl.push_back('{1'b0, 2'd3, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 2'd0, 8'h00, 8'h00});
    tbl.push_back('{1'b1, 2'd2, 8'h03, 8'h00});
    tbl.push_back('{1'b0, 2'd2, 8'h00, 8'h03});
    tbl.push_back('{1'b1, 2'd2, 8'hFE, 8'h03});
    tbl.push_back('{1'b0, 2'd2, 8'h00, 8'h06});
    tbl.push_back('{1'b1, 2'd0, 8'h55, 8'h06});
    tbl.push_back('{1'b0, 2'd3, 8'h00, 8'h00});
    tbl.push_back('{1'b1, 2'd3, 8'h77, 8'h00});
    tbl.push_back('{1'b0, 2'd1, 8'h00, 8'h00});
    tbl.push_back('{1'b1, 2'd1, 8'h0C, 8'h00});
`ifdef UART_RX_CTRL_IRQ_EN
    tbl.push_back('{1'b0, 2'd1, 8'h00, 8'h08});
`else
    tbl.push_back('{1'b0, 2'd1, 8'h00, 8'h00});
`endif
    tbl.push_back('{1'b1, 2'd1, 8'h00, tbl[tbl.size()-1].exp});
    tbl.push_back('{1'b0, 2'd1, 8'h00, 8'h00});
    tbl.push_back('{1'b1, 2'd2, 8'h05, 8'h00});
    tbl.push_back('{1'b0, 2'd2, 8'h00, 8'h05});
    foreach (tbl[i]) begin
      cs = 1; we = tbl[i].w; addr = tbl[i].a; wdata = tbl[i].d;
      tick();
      cs = 0; we = 0;
      m_cpu(tbl[i].w, tbl[i].a, tbl[i].d);
      check($sformatf("tbl%0d rdata", i), rdata, tbl[i].exp);
    end
    check("tbl baud", baudrate, 3'b101);

    // Single byte with valid held well past ready.
    send(8'hA5, 3, 0, 0, 0, 0, "single");
    cpu(0, 2'd3, 0, "single level1");
    check("single level const", rdata, 8'h01);
    cpu(0, 2'd0, 0, "single data");
    check("single data const", rdata, 8'hA5);
    cpu(0, 2'd3, 0, "single level0");

    // Overflow by one byte.
    for (int i = 0; i < 17; i++) send(8'(i), 0, 0, 0, 0, 0, $sformatf("ovf%0d", i));
    cpu(0, 2'd1, 0, "ovf status");
    check("ovf status const", rdata, 8'h07);
    for (int i = 0; i < 16; i++) cpu(0, 2'd0, 0, $sformatf("ovf rd%0d", i));
    cpu(0, 2'd1, 0, "ovf status drained");
    cpu(1, 2'd1, 8'h04, "ovf clear");
    cpu(0, 2'd1, 0, "ovf status cleared");

    // Full FIFO: pop on the capture edge makes room, no overrun.
    for (int i = 0; i < 16; i++) send(8'(8'h20 + i), 0, 0, 0, 0, 0, $sformatf("fill%0d", i));
    send(8'h99, 0, 1, 1'b0, 2'd0, 8'h00, "full pushpop");
    cpu(0, 2'd3, 0, "full pushpop level");
    check("full pushpop level const", rdata, 8'h10);
    cpu(0, 2'd1, 0, "full pushpop status");
    for (int i = 0; i < 16; i++) cpu(0, 2'd0, 0, $sformatf("full drain%0d", i));
    check("full last out", rdata, 8'h99);

    // Empty FIFO: same-edge pop returns 0, pushed byte stays.
    send(8'h5A, 0, 1, 1'b0, 2'd0, 8'h00, "empty pushpop");
    cpu(0, 2'd3, 0, "empty pushpop level");
    cpu(0, 2'd0, 0, "empty pushpop data");

    // Overrun clear collides with a new overrun.
    for (int i = 0; i < 16; i++) send(8'(8'h40 + i), 0, 0, 0, 0, 0, $sformatf("fill2_%0d", i));
    send(8'hEE, 0, 1, 1'b1, 2'd1, 8'h04, "clr vs ovr");
    cpu(0, 2'd1, 0, "clr vs ovr status");
    for (int i = 0; i < 16; i++) cpu(0, 2'd0, 0, $sformatf("drain2_%0d", i));
    cpu(1, 2'd1, 8'h04, "clr2");

    // Baud change with bytes queued.
    send(8'h31, 0, 0, 0, 0, 0, "baud b0");
    send(8'h32, 0, 0, 0, 0, 0, "baud b1");
    cpu(1, 2'd2, 8'h01, "baud wr");
    check("baud out", baudrate, 3'b001);
    cpu(0, 2'd2, 0, "baud rd");
    cpu(0, 2'd3, 0, "baud level");
    cpu(0, 2'd0, 0, "baud d0");
    cpu(0, 2'd0, 0, "baud d1");

`ifdef UART_RX_CTRL_IRQ_EN
    cpu(1, 2'd1, 8'h08, "irq en");
    tick();
    check("irq idle", irq, 0);
    rx_data = 8'h11; rx_data_valid = 1;
    tick();
    check("irq capture ready", rx_data_ready, 1);
    check("irq lag", irq, 0);
    m_push(8'h11);
    tick();
    check("irq set", irq, 1);
    rx_data_valid = 0;
    repeat (3) tick();
    cpu(0, 2'd0, 0, "irq pop");
    check("irq hold", irq, 1);
    tick();
    check("irq clr", irq, 0);
    cpu(1, 2'd1, 8'h00, "irq dis");
`endif

    // Reset while the receiver still holds valid.
    cpu(1, 2'd2, 8'h02, "pre-rst baud");
    rx_data = 8'h3C; rx_data_valid = 1;
    repeat (3) tick();
    rst_n = 0;
    #1;
    check("midrst ready", rx_data_ready, 0);
    check("midrst baud", baudrate, 3'b101);
    check("midrst rdata", rdata, 8'h00);
    tick();
    rst_n = 1;
    m_reset();
    send(8'h3C, 0, 0, 0, 0, 0, "post-rst");
    cpu(0, 2'd3, 0, "post-rst level");
    cpu(0, 2'd0, 0, "post-rst data");

    // Random traffic vs the model.
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      rb = 8'($urandom);
      if (op < 5)       send(rb, int'($urandom_range(0, 2)), 0, 0, 0, 0, $sformatf("rnd%0d send", n));
      else if (op < 7)  cpu(0, 2'd0, 8'h00, $sformatf("rnd%0d pop", n));
      else if (op == 7) cpu(0, 2'($urandom), 8'h00, $sformatf("rnd%0d rd", n));
      else              cpu(1, 2'($urandom), rb, $sformatf("rnd%0d wr", n));
      tick();
      check($sformatf("rnd%0d baud", n), baudrate, m_baud);
      check($sformatf("rnd%0d irq", n), irq, m_irq());
      check($sformatf("rnd%0d ready idle", n), rx_data_ready, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
